// File: rtl/os_pkg.sv
// os_pkg: shared widths, the ceil-log2 helper and state encodings for os_discard
package os_pkg;
  localparam int PART_N      = 16;
  localparam int IFFT_W      = 12;
  localparam int FX_NARROW_W = 9;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN} state_t;
endpackage

// File: rtl/fx_round_sat.sv
// fx_round_sat: round-half-up by SHIFT then saturate x (WI signed) to y (WO signed)
module fx_round_sat #(
  parameter int WI    = 12,
  parameter int WO    = 9,
  parameter int SHIFT = 3
) (
  input  logic signed [WI-1:0] x,
  output logic signed [WO-1:0] y
);
  localparam logic signed [WI:0] MAXV = (WI+1)'((1 << (WO-1)) - 1);
  localparam logic signed [WI:0] MINV = (WI+1)'(-(1 << (WO-1)));
  logic signed [WI:0] t, s;
  assign t = {x[WI-1], x} + (WI+1)'(1 << (SHIFT-1));
  assign s = t >>> SHIFT;
  assign y = s > MAXV ? MAXV[WO-1:0] : s < MINV ? MINV[WO-1:0] : s[WO-1:0];
endmodule

// File: rtl/os_discard.sv
// os_discard: keep last N of each 2N IFFT frame, round/saturate, stream out under valid/ready
module os_discard
  import os_pkg::*;
#(
  parameter int N     = PART_N,
  parameter int WI    = IFFT_W,
  parameter int WO    = FX_NARROW_W,
  parameter int SHIFT = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_ifft_start,
  input  logic                 i_ifft_valid,
  input  logic signed [WI-1:0] i_yI,
  input  logic signed [WI-1:0] i_yQ,
  output logic                 o_in_ready,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic signed [WO-1:0] o_yI,
  output logic signed [WO-1:0] o_yQ,
  output logic                 o_frame_err
);
  localparam int CW = clog2(2*N);
  localparam int DW = clog2(N);
  state_t state, state_n;
  logic [CW-1:0] cap_idx;
  logic [DW-1:0] drn_idx;
  logic [WO-1:0] mem_i [N];
  logic [WO-1:0] mem_q [N];
  logic signed [WO-1:0] r_i, r_q;
  logic cap_v, last_cap, last_drn, fire;
  fx_round_sat #(.WI(WI), .WO(WO), .SHIFT(SHIFT)) u_ri (.x(i_yI), .y(r_i));
  fx_round_sat #(.WI(WI), .WO(WO), .SHIFT(SHIFT)) u_rq (.x(i_yQ), .y(r_q));
  assign cap_v      = state == S_CAPTURE && i_ifft_valid && !i_ifft_start;
  assign last_cap   = cap_idx == CW'(2*N-1);
  assign last_drn   = drn_idx == DW'(N-1);
  assign o_valid    = state == S_DRAIN;
  assign o_in_ready = state != S_DRAIN;
  assign fire       = o_valid && i_ready;
  assign o_yI       = o_valid ? mem_i[drn_idx] : '0;
  assign o_yQ       = o_valid ? mem_q[drn_idx] : '0;
  always_comb begin
    state_n = state;
    state_n = state == S_IDLE    ? (i_ifft_start ? S_CAPTURE : S_IDLE) :
              state == S_CAPTURE ? (cap_v && last_cap ? S_DRAIN : S_CAPTURE) :
                                   (fire && last_drn ? S_IDLE : S_DRAIN);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      cap_idx     <= '0;
      drn_idx     <= '0;
      o_frame_err <= 1'b0;
    end else begin
      state       <= state_n;
      o_frame_err <= i_ifft_start && state != S_IDLE;
      cap_idx     <= i_ifft_start ? '0 : cap_v ? (last_cap ? '0 : cap_idx + 1'b1) : cap_idx;
      drn_idx     <= fire ? (last_drn ? '0 : drn_idx + 1'b1) : drn_idx;
    end
  end
  always_ff @(posedge i_clk) begin
    if (cap_v && cap_idx >= CW'(N)) begin
      mem_i[DW'(cap_idx - CW'(N))] <= r_i;
      mem_q[DW'(cap_idx - CW'(N))] <= r_q;
    end
  end
endmodule

// File: tb/tb_os_discard.sv
// tb_os_discard: scoreboard bench for os_discard
module tb_os_discard;
  logic clk = 0, rst = 1, start = 0, valid = 0, stall = 0, bp = 0;
  logic signed [11:0] yi = 0, yq = 0;
  logic in_ready, o_valid, i_ready, frame_err;
  logic signed [8:0] o_yi, o_yq;
  int checks = 0, failures = 0, err_cnt = 0, xfer = 0, cyc = 0;
  int fi [32], fq [32], ei [32], eq [32];
  logic [17:0] q [$];
  logic pv = 0, pr = 0;
  logic signed [8:0] pi, pq;
  localparam logic [3:0] PAT = 4'b1001;

  os_discard dut (
    .i_clk(clk), .i_rst(rst), .i_ifft_start(start), .i_ifft_valid(valid),
    .i_yI(yi), .i_yQ(yq), .o_in_ready(in_ready), .o_valid(o_valid),
    .i_ready(i_ready), .o_yI(o_yi), .o_yQ(o_yq), .o_frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) #1 cyc++;
  assign i_ready = !stall && (!bp || PAT[cyc[1:0]]);

  task automatic check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) pv = 0;
    else begin
      if (frame_err) err_cnt++;
      if (o_valid) check(!in_ready, "in_ready_drain", int'(in_ready), 0);
      if (pv && !pr) begin
        check(o_valid, "stall_valid", int'(o_valid), 1);
        check(o_yi == pi && o_yq == pq, "stall_hold", int'(o_yi), int'(pi));
      end
      if (o_valid && i_ready) begin
        if (q.size() == 0) check(0, "unexpected_out", int'(o_yi), 0);
        else begin
          logic [17:0] e;
          e = q.pop_front();
          check(o_yi == $signed(e[17:9]), "out_yI", int'(o_yi), int'($signed(e[17:9])));
          check(o_yq == $signed(e[8:0]), "out_yQ", int'(o_yq), int'($signed(e[8:0])));
        end
        xfer++;
      end
      pv = o_valid; pr = i_ready; pi = o_yi; pq = o_yq;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_partial(input int n);
    start = 1; tick(); start = 0;
    for (int k = 0; k < n; k++) begin
      valid = 1; yi = 12'(fi[k]); yq = 12'(fq[k]); tick();
    end
    valid = 0;
  endtask

  task automatic send_frame(input int npush, input bit gaps);
    start = 1; tick(); start = 0;
    for (int k = 0; k < 32; k++) begin
      valid = 1; yi = 12'(fi[k]); yq = 12'(fq[k]);
      if (k >= 16 && k - 16 < npush) q.push_back({9'(ei[k]), 9'(eq[k])});
      tick();
      valid = 0;
      if (gaps && k % 3 == 0 && k != 31) tick();
    end
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while ((q.size() != 0 || o_valid) && n < 300) begin tick(); n++; end
    check(q.size() == 0 && !o_valid, name, q.size(), 0);
    tick(); tick();
  endtask

  task automatic ramp();
    for (int k = 0; k < 32; k++) begin
      fi[k] = k * 8; fq[k] = -k * 8; ei[k] = k; eq[k] = -k;
    end
  endtask

  initial begin
    int base, cnt, n;
    ramp();
    repeat (3) tick();
    check(!o_valid && o_yi == 0 && o_yq == 0, "rst_out", int'(o_valid), 0);
    check(!frame_err && in_ready, "rst_flags", int'(in_ready), 1);
    rst = 0; tick();

    send_frame(16, 0);
    cnt = 0;
    repeat (16) begin @(negedge clk); if (o_valid) cnt++; end
    check(cnt == 16, "basic_burst", cnt, 16);
    @(negedge clk);
    check(!o_valid, "basic_end", int'(o_valid), 0);
    wait_empty("basic_drain");

    ramp();
    for (int k = 0; k < 16; k++) begin fi[k] = 2047; fq[k] = -2048; end
    fi[16] = 100;   ei[16] = 13;   fq[16] = 3;     eq[16] = 0;
    fi[17] = -100;  ei[17] = -12;  fq[17] = 4;     eq[17] = 1;
    fi[18] = 2047;  ei[18] = 255;  fq[18] = -2048; eq[18] = -256;
    fi[19] = -2048; ei[19] = -256; fq[19] = 2047;  eq[19] = 255;
    fi[20] = 4;     ei[20] = 1;    fq[20] = -100;  eq[20] = -12;
    fi[21] = 3;     ei[21] = 0;    fq[21] = 100;   eq[21] = 13;
    send_frame(16, 1);
    wait_empty("round_drain");

    ramp();
    for (int k = 0; k < 32; k++) begin fi[k] = 7 - k * 24; ei[k] = (7 - k * 24 + 4) >>> 3; end
    base = xfer; bp = 1;
    send_frame(16, 0);
    wait_empty("bp_drain");
    bp = 0;
    check(xfer - base == 16, "bp_count", xfer - base, 16);

    base = err_cnt;
    for (int k = 0; k < 32; k++) begin fi[k] = 1000; fq[k] = -1000; end
    send_partial(10);
    ramp();
    send_frame(16, 0);
    wait_empty("ferr_drain");
    check(err_cnt - base == 1, "ferr_pulses", err_cnt - base, 1);

    base = xfer;
    for (int k = 0; k < 5; k++) begin valid = 1; yi = 12'(400); yq = 12'(400); tick(); end
    valid = 0;
    repeat (5) tick();
    check(xfer == base && !o_valid, "stray_idle", xfer - base, 0);
    base = err_cnt;
    for (int k = 0; k < 32; k++) begin fi[k] = 8 * (31 - k); fq[k] = 8 * k; ei[k] = 31 - k; eq[k] = k; end
    send_frame(16, 0);
    start = 1; valid = 1; yi = 12'(-800); yq = 12'(-800); tick();
    start = 0; valid = 0;
    wait_empty("stray_drain");
    check(err_cnt - base == 1, "stray_err", err_cnt - base, 1);

    ramp();
    base = xfer;
    send_frame(5, 0);
    n = 0;
    while (xfer < base + 5 && n < 100) begin tick(); n++; end
    check(xfer == base + 5, "rst_mid_count", xfer - base, 5);
    stall = 1; rst = 1; tick();
    @(negedge clk);
    check(!o_valid && in_ready, "rst_mid_idle", int'(o_valid), 0);
    rst = 0; stall = 0; tick();
    check(q.size() == 0, "rst_mid_q", q.size(), 0);
    for (int k = 0; k < 32; k++) begin fi[k] = -8 * k; fq[k] = 8 * k + 4; ei[k] = -k; eq[k] = k + 1; end
    send_frame(16, 0);
    wait_empty("post_rst_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1);
  end
endmodule
